// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file writeback controller.
package regfile_ctrl_pkg;

    localparam int N     = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [N-1:0]  data;
    } wb_req_t;

    function automatic logic [DEPTH-1:0] rd_onehot(input logic [AW-1:0] rd);
        rd_onehot     = '0;
        rd_onehot[rd] = 1'b1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request channel: valid/ready handshake carrying rd and data.
interface regfile_wb_arbiter_if;
    import regfile_ctrl_pkg::*;

    logic    valid;
    logic    ready;
    wb_req_t req;

    modport master (output valid, output req, input ready);
    modport slave  (input valid, input req, output ready);

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; pointer names the preferred requester.
module rr_arb2
    import regfile_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (req == 2'b11): gnt[ptr] = 1'b1;
            (req == 2'b01): gnt[0]   = 1'b1;
            (req == 2'b10): gnt[1]   = 1'b1;
            default:        gnt      = 2'b00;
        endcase
    end

    // After an ALU grant the LSU becomes preferred, and vice versa.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'(REQ_ALU);
        end else if (|gnt) begin
            ptr <= gnt[REQ_ALU];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback port arbiter and pending-write scoreboard for the register file.
// Define WB_BYPASS_EN to add the combinational read-forwarding ports.
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ready,
    regfile_wb_arbiter_if.slave alu,
    regfile_wb_arbiter_if.slave lsu,
    output logic             wr_en,
    output logic [AW-1:0]    wr_rd,
    output logic [N-1:0]     wr_data,
    output logic [DEPTH-1:0] busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [N-1:0]     rdata1_in,
    input  logic [N-1:0]     rdata2_in,
    output logic [N-1:0]     fwd1,
    output logic [N-1:0]     fwd2
`endif
);

    logic [1:0]       req;
    logic [1:0]       gnt;
    wb_req_t          win;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;

    assign req = {lsu.valid, alu.valid} & {2{~rst}};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign alu.ready = gnt[REQ_ALU];
    assign lsu.ready = gnt[REQ_LSU];
    assign win       = gnt[REQ_LSU] ? lsu.req : alu.req;

    assign issue_ready = ~rst & ~(busy[issue_rd] & (issue_rd != '0));

    assign set_vec = (issue_valid && issue_ready && issue_rd != '0)
                   ? rd_onehot(issue_rd) : '0;
    assign clr_vec = wr_en ? rd_onehot(wr_rd) : '0;

    // OR-ing the set after the clear lets a same-cycle issue win.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
            busy    <= '0;
        end else begin
            wr_en <= (|gnt) && (win.rd != '0);
            if (|gnt) begin
                wr_rd   <= win.rd;
                wr_data <= win.data;
            end
            busy <= ((busy & ~clr_vec) | set_vec) & ~DEPTH'(1);
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd1 = (wr_en && wr_rd == rs1 && rs1 != '0) ? wr_data : rdata1_in;
    assign fwd2 = (wr_en && wr_rd == rs2 && rs2 != '0) ? wr_data : rdata2_in;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback controller for the 32x32 register file: arbitrates the single register-file write port between the ALU and load/store writeback requesters. It tracks pending destination registers in a scoreboard so issue logic can stall on hazards. It sits between the execute/memory stages and the register file, driving its write enable, write address and write data.

## Interface
- N, 32, data width
- DEPTH, 32, number of architectural registers
- AW, 5, register index width (log2 DEPTH)
- clk  in  1  rising-edge clock, shared with register file
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode issues an instruction writing issue_rd
- issue_rd  in  AW  destination of issuing instruction
- issue_ready  out  1  combinational; 0 when busy[issue_rd]=1 and issue_rd!=0
- alu_valid / alu_rd / alu_data  in  1 / AW / N  ALU writeback request
- alu_ready  out  1  combinational grant to ALU
- lsu_valid / lsu_rd / lsu_data  in  1 / AW / N  load writeback request
- lsu_ready  out  1  combinational grant to LSU
- wr_en  out  1  registered; drives register file mem_write
- wr_rd  out  AW  registered write index (register file rd)
- wr_data  out  N  registered write data
- busy  out  DEPTH  registered scoreboard, bit i = write to xi pending
- (WB_BYPASS_EN only) rs1, rs2 in AW; rdata1_in, rdata2_in in N; fwd1, fwd2 out N

## Operation
- Handshake: transfer when valid && ready, same cycle. Requesters hold rd/data stable while valid && !ready.
- Arbitration: two-way round-robin. At most one ready per cycle. Only one valid gets granted. Both valid grant the requester not granted last. After reset the ALU has priority.
- Issue: issue_valid && issue_ready sets busy[issue_rd] (unless rd=0).
- Writeback: a granted transfer loads wr_en=1, wr_rd, and wr_data next edge. An rd=0 transfer is accepted (ready=1) but loads wr_en=0; x0 is never written.
- Scoreboard clear: on the edge where wr_en=1, busy[wr_rd] clears.
- Simultaneous set and clear of the same index: set wins.
- busy[0] is constant 0.
- Writeback to a non-busy register is legal; data is written and busy is unchanged.

## Timing
- Reset values: wr_en=0, wr_rd=0, wr_data=0, busy=0, round-robin pointer = ALU preferred.
- Grant in cycle N. wr_* valid in cycle N+1. The register file commits at the end of N+1. busy bit reads 0 from N+2, the same cycle the new value is readable.
- Throughput 1 writeback/cycle. A losing requester waits at most 1 cycle when the other stays valid.
- Reset mid-operation: the in-flight registered write is dropped (wr_en=0 next cycle), and all busy bits clear.
- With rst high, ready outputs are 0 and issue_ready is 0.

## Configuration
- WB_BYPASS_EN defined: bypass ports exist.
  - fwd1 = wr_data when wr_en && wr_rd==rs1 && rs1!=0, else rdata1_in. fwd2 follows the same rule with rs2 and rdata2_in.
  - Forwarding is purely combinational and covers the cycle before commit.
- WB_BYPASS_EN undefined: bypass ports and logic are absent. Consumers wait for busy to drop, one extra cycle.

## Structure
- Package regfile_ctrl_pkg holds:
  - constants N, DEPTH, AW;
  - requester index constants REQ_ALU=0 and REQ_LSU=1;
  - the writeback request struct type (rd, data).
- Sub-module rr_arb2 is a 2-way round-robin arbiter (req[1:0] -> gnt[1:0], with its own pointer register reset to REQ_ALU).
- Scoreboard, output registers and bypass logic live in the top module.

## Test plan
- Reset, then issue rd=5. Cycle after: busy[5]=1. ALU writes rd=5, data=0xDEADBEEF. Next cycle wr_en=1, wr_rd=5, wr_data=0xDEADBEEF. busy[5]=0 one cycle later.
- ALU and LSU valid together for 4 cycles, rd=3 and rd=4. Grants alternate ALU, LSU, ALU, LSU; wr_rd sequence 3,4,3,4.
- Issue rd=7 while busy[7]=1 -> issue_ready=0. Issue rd=0 -> issue_ready=1 with no busy bit set.
- LSU writes rd=0 with data=0x1 -> lsu_ready=1, wr_en stays 0, busy unchanged.
- issue_rd=9 in the same cycle as wr_en=1, wr_rd=9 -> busy[9] remains 1.
- WB_BYPASS_EN: wr_en=1, wr_rd=6, wr_data=0x55, rs1=6, rdata1_in=0x11 -> fwd1=0x55. rs1=0 -> fwd1=rdata1_in.
- rst pulsed while wr_en pending -> next cycle wr_en=0 and busy=0.
